// File: rtl/instr_encoder_pkg.sv
// Shared instruction-kind enum, MIPS opcode/funct constants and the writer
// FSM state type. The decoder imports the same opcode/funct constants.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    KIND_ADD  = 3'd0,
    KIND_SUB  = 3'd1,
    KIND_ADDI = 3'd2,
    KIND_LW   = 3'd3,
    KIND_SW   = 3'd4,
    KIND_BEQ  = 3'd5,
    KIND_J    = 3'd6,
    KIND_NOP  = 3'd7
  } kind_e;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;

  // IDLE: buffer empty; RUN: words waiting to be written; FULL: imem exhausted
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } enc_state_e;

  // Control-transfer instructions that get a delay-slot NOP when padding is on
  function automatic logic needs_pad(kind_e k);
    return (k == KIND_BEQ) || (k == KIND_J);
  endfunction

endpackage

// File: rtl/instr_encoder_enc_fifo.sv
// Synchronous 32-bit FIFO for encoded words. Accepts one or two words per
// push (second word lands in the following slot), one pop per cycle, and a
// flush that empties it. Caller guarantees no overflow/underflow.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          push2_i,
  input  logic [31:0]   w0_i,
  input  logic [31:0]   w1_i,
  input  logic          pop_i,
  output logic [31:0]   head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] n_push;

  assign n_push  = !push_i ? '0 : (push2_i ? CW'(2) : CW'(1));
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Storage write; flush wins so words pushed in a flush cycle are dropped
  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !rst_i) begin
      mem_q[wr_q] <= w0_i;
      if (push2_i) begin
        mem_q[wr_q + PW'(1)] <= w1_i;
      end
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + PW'(n_push);
      if (pop_i) begin
        rd_q <= rd_q + PW'(1);
      end
      cnt_q <= cnt_q + n_push - CW'(pop_i);
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction writer: encodes symbolic requests into MIPS-subset words,
// buffers them and streams them into imem from BASE_ADDR upward, stopping
// (FULL) after the last imem word. Build macro ENC_DELAY_SLOT_PAD_EN adds a
// NOP after every BEQ/J.
//
// Handshakes: a request transfers on a cycle where req_valid && req_ready;
// a word transfers to imem on a cycle where imem_we && imem_ready, and
// imem_we/imem_addr/imem_wdata hold steady until that happens.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  input  logic              rewind,
  input  logic              imem_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              imem_full,
  output logic [ADDR_W:0]   word_count,
  output logic [1:0]        dbg_state
);

  localparam int                CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = '1;

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;

  kind_e         kind;
  logic          pad_req;
  logic          accept;
  logic          pop;
  logic          last_write;
  logic          flush;
  logic [31:0]   enc_word;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] n_words;
  logic [CW-1:0] occ_next;

  function automatic logic [31:0] encode(kind_e k, logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] rd, logic [15:0] imm,
                                         logic [25:0] tgt);
    case (k)
      KIND_ADD:  return {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADD};
      KIND_SUB:  return {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_SUB};
      KIND_ADDI: return {OP_ADDI, rs, rt, imm};
      KIND_LW:   return {OP_LW, rs, rt, imm};
      KIND_SW:   return {OP_SW, rs, rt, imm};
      KIND_BEQ:  return {OP_BEQ, rs, rt, imm};
      KIND_J:    return {OP_J, tgt};
      default:   return 32'h0;
    endcase
  endfunction

  assign kind     = kind_e'(req_kind);
  assign enc_word = encode(kind, req_rs, req_rt, req_rd, req_imm, req_target);

`ifdef ENC_DELAY_SLOT_PAD_EN
  assign pad_req = needs_pad(kind);
`else
  assign pad_req = 1'b0;
`endif

  // Ready uses current occupancy only: no credit for a pop in the same cycle
  assign free_slots = CW'(FIFO_DEPTH) - fifo_count;
  assign req_ready  = !rst && !rewind && (state_q != S_FULL) &&
                      (free_slots >= (pad_req ? CW'(2) : CW'(1)));
  assign accept     = req_valid && req_ready;
  assign n_words    = !accept ? '0 : (pad_req ? CW'(2) : CW'(1));

  // RUN always means the buffer holds at least one word
  assign imem_we    = !rst && !rewind && (state_q == S_RUN);
  assign pop        = imem_we && imem_ready;
  assign last_write = pop && (addr_q == LAST);
  assign flush      = rewind || last_write;
  assign occ_next   = fifo_count + n_words - CW'(pop);

  assign imem_addr  = addr_q;
  assign imem_wdata = imem_we ? fifo_head : 32'h0;
  assign imem_full  = (state_q == S_FULL);
  assign word_count = wcnt_q;
  assign dbg_state  = state_q;

  enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (accept),
    .push2_i (accept && pad_req),
    .w0_i    (enc_word),
    .w1_i    (32'h0),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  // Next state, address and word count; rewind overrides everything
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    if (rewind) begin
      state_d = S_IDLE;
      addr_d  = BASE;
      wcnt_d  = '0;
    end else begin
      if (pop) begin
        wcnt_d = wcnt_q + (ADDR_W+1)'(1);
        if (!last_write) begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      case (state_q)
        S_FULL: state_d = S_FULL;
        default: begin
          if (last_write) begin
            state_d = S_FULL;
          end else if (occ_next != '0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= BASE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule
